// File: rtl/vdp_host_port.sv
// vdp_host_port
//   Host-side byte port into video memory and the control register file.
//   Control bytes come in pairs. The first byte is latched. The second byte
//   then sets the VRAM address, writes a register, or (with readback)
//   sets the address and starts a prefetch. Data bytes stream into VRAM
//   at the current address, and the address auto-increments after each access.
//
//   Build option: define VDP_READBACK_EN to build the read path (read buffer,
//   RD_PEND/RD_WAIT, host_rd, vram_re). When it is undefined, host_rd is
//   ignored and host_rdata, host_rvalid and vram_re are tied to 0.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   host_valid/host_ready   byte handshake; host_mode 1 = control, 0 = data
//   host_wdata              host byte
//   host_rd                 level read request, held until host_rvalid
//   host_rdata/host_rvalid  read byte with a one-cycle acknowledge
//   vram_addr/wdata/we/re   VRAM request, held until vram_gnt
//   vram_gnt, vram_rdata    arbiter grant; read data arrives the cycle after grant
//   reg_we/reg_sel/wdata    one-cycle register write
//   latch_pending           first control byte is held
module vdp_host_port #(
  parameter int ADDR_W     = 14,
  parameter int NREGS_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_mode,
  input  logic [7:0]            host_wdata,
  input  logic                  host_rd,
  output logic [7:0]            host_rdata,
  output logic                  host_rvalid,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [7:0]            vram_wdata,
  output logic                  vram_we,
  output logic                  vram_re,
  input  logic                  vram_gnt,
  input  logic [7:0]            vram_rdata,
  output logic                  reg_we,
  output logic [NREGS_LOG2-1:0] reg_sel,
  output logic [7:0]            reg_wdata,
  output logic                  latch_pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PEND = 2'd1
`ifdef VDP_READBACK_EN
   ,RD_PEND = 2'd2,
    RD_WAIT = 2'd3
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        lo_latch;
  logic [ADDR_W-1:0] addr_inc;
  logic [13:0]       ctl_raw;
  logic [ADDR_W-1:0] ctl_addr;

  // The address counter wraps naturally at 2^ADDR_W.
  assign addr_inc   = addr + ADDR_W'(1);
  // The second control byte supplies the upper six address bits, and the
  // latched first byte supplies the lower eight.
  assign ctl_raw    = {host_wdata[5:0], lo_latch};
  assign ctl_addr   = ADDR_W'(ctl_raw);
  assign host_ready = (state == IDLE);

`ifdef VDP_READBACK_EN
  logic [7:0] rd_buf;
  logic       buf_valid;
`else
  // Without readback, the read-side inputs have no effect.
  logic unused_rd;
  assign unused_rd   = ^{host_rd, vram_rdata};
  assign host_rdata  = 8'h00;
  assign host_rvalid = 1'b0;
  assign vram_re     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      addr          <= '0;
      lo_latch      <= 8'h00;
      latch_pending <= 1'b0;
      vram_addr     <= '0;
      vram_wdata    <= 8'h00;
      vram_we       <= 1'b0;
      reg_we        <= 1'b0;
      reg_sel       <= '0;
      reg_wdata     <= 8'h00;
`ifdef VDP_READBACK_EN
      vram_re       <= 1'b0;
      host_rdata    <= 8'h00;
      host_rvalid   <= 1'b0;
      rd_buf        <= 8'h00;
      buf_valid     <= 1'b0;
`endif
    end else begin
      // Default to no strobe, so that each pulse lasts exactly one cycle.
      reg_we <= 1'b0;
`ifdef VDP_READBACK_EN
      host_rvalid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (host_valid) begin
            if (host_mode) begin
              if (!latch_pending) begin
                lo_latch      <= host_wdata;
                latch_pending <= 1'b1;
              end else begin
                latch_pending <= 1'b0;
                case (host_wdata[7:6])
                  2'b01: addr <= ctl_addr;
                  2'b00: begin
                    addr <= ctl_addr;
`ifdef VDP_READBACK_EN
                    // Read setup: fetch the first byte ahead of host_rd.
                    vram_addr <= ctl_addr;
                    vram_re   <= 1'b1;
                    state     <= RD_PEND;
`endif
                  end
                  2'b10: begin
                    reg_we    <= 1'b1;
                    reg_sel   <= host_wdata[NREGS_LOG2-1:0];
                    reg_wdata <= lo_latch;
                  end
                  default: ;
                endcase
              end
            end else begin
              latch_pending <= 1'b0;
              vram_addr     <= addr;
              vram_wdata    <= host_wdata;
              vram_we       <= 1'b1;
              state         <= WR_PEND;
`ifdef VDP_READBACK_EN
              // The prefetched byte may now be stale.
              buf_valid     <= 1'b0;
`endif
            end
          end
`ifdef VDP_READBACK_EN
          // An accepted host byte takes priority, and the read waits.
          else if (host_rd && buf_valid) begin
            host_rdata  <= rd_buf;
            host_rvalid <= 1'b1;
            buf_valid   <= 1'b0;
            vram_addr   <= addr;
            vram_re     <= 1'b1;
            state       <= RD_PEND;
          end
`endif
        end
        WR_PEND: begin
          if (vram_gnt) begin
            vram_we <= 1'b0;
            addr    <= addr_inc;
            state   <= IDLE;
          end
        end
`ifdef VDP_READBACK_EN
        RD_PEND: begin
          if (vram_gnt) begin
            vram_re <= 1'b0;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rd_buf    <= vram_rdata;
          buf_valid <= 1'b1;
          addr      <= addr_inc;
          state     <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_host_port.sv
// Testbench for vdp_host_port. It drives a randomized grant and runs directed
// and random byte streams. The results are checked against a byte-level
// model of the address/latch rules.
module tb_vdp_host_port;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        host_valid, host_ready, host_mode, host_rd, host_rvalid;
  logic [7:0]  host_wdata, host_rdata;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        vram_we, vram_re, vram_gnt;
  logic        reg_we, latch_pending;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_wdata;

  always #10 clk = ~clk;

  vdp_host_port #(.ADDR_W(14), .NREGS_LOG2(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_mode(host_mode),
    .host_wdata(host_wdata), .host_rd(host_rd), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_we(vram_we), .vram_re(vram_re), .vram_gnt(vram_gnt),
    .vram_rdata(vram_rdata), .reg_we(reg_we), .reg_sel(reg_sel),
    .reg_wdata(reg_wdata), .latch_pending(latch_pending)
  );

  int checks = 0;
  int failures = 0;

  // Grant driver: 0 = always granted, 1 = random, 2 = hold low for hold_cnt busy cycles.
  int gnt_mode = 0;
  int hold_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (gnt_mode)
      0: vram_gnt = 1'b1;
      1: vram_gnt = 1'($urandom_range(0, 1));
      default: begin
        if ((vram_we || vram_re) && hold_cnt > 0) begin
          vram_gnt = 1'b0;
          hold_cnt = hold_cnt - 1;
        end else vram_gnt = 1'b1;
      end
    endcase
  end

  // VRAM behavioural memory. The poke port lets the bench preload bytes.
  logic [7:0]  mem [0:16383];
  logic        poke_en = 1'b0;
  logic [13:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (vram_we && vram_gnt) mem[vram_addr] <= vram_wdata;
    if (vram_re && vram_gnt) vram_rdata <= mem[vram_addr];
  end

  // Observed traffic and protocol counters.
  logic [21:0] act_wq[$];
  logic [10:0] act_rq[$];
  int we_cycles = 0, both_hi = 0, unstable = 0, busy_ready = 0;
  logic        p_we = 1'b0, p_gnt = 1'b0;
  logic [21:0] p_ad = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (vram_we) we_cycles <= we_cycles + 1;
      if (vram_we && vram_re) both_hi <= both_hi + 1;
      if ((vram_we || vram_re) && host_ready) busy_ready <= busy_ready + 1;
      if (vram_we && vram_gnt) act_wq.push_back({vram_addr, vram_wdata});
      if (reg_we) act_rq.push_back({reg_sel, reg_wdata});
      if (p_we && !p_gnt && vram_we && ({vram_addr, vram_wdata} != p_ad))
        unstable <= unstable + 1;
    end
    p_we  <= vram_we && reset_n;
    p_gnt <= vram_gnt;
    p_ad  <= {vram_addr, vram_wdata};
  end

  // Reference model at the byte level.
  logic [7:0]  ref_mem [0:16383];
  logic [13:0] m_addr = '0;
  logic [7:0]  m_lo = '0, m_buf = '0;
  logic        m_pend = 1'b0;
  logic [21:0] exp_wq[$];
  logic [10:0] exp_rq[$];

  task automatic model_byte(input logic m, input logic [7:0] d);
    if (m) begin
      if (!m_pend) begin
        m_lo = d; m_pend = 1'b1;
      end else begin
        m_pend = 1'b0;
        if (d[7:6] == 2'b01) m_addr = {d[5:0], m_lo};
        else if (d[7:6] == 2'b00) begin
          m_addr = {d[5:0], m_lo};
`ifdef VDP_READBACK_EN
          m_buf  = ref_mem[m_addr];
          m_addr = m_addr + 14'd1;
`endif
        end else if (d[7:6] == 2'b10) exp_rq.push_back({d[2:0], m_lo});
      end
    end else begin
      m_pend = 1'b0;
      exp_wq.push_back({m_addr, d});
      ref_mem[m_addr] = d;
      m_addr = m_addr + 14'd1;
    end
  endtask

  // Offer one byte and wait (bounded) until it is accepted.
  task automatic send_byte(input logic m, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!host_ready && n < 200) begin @(negedge clk); n++; end
    if (!host_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: host_ready=%b after %0d cycles, required 1", host_ready, n);
    end
    host_valid = 1'b1; host_mode = m; host_wdata = d;
    @(posedge clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic put(input logic m, input logic [7:0] d);
    send_byte(m, d);
    model_byte(m, d);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!host_ready && n < 400) begin @(negedge clk); n++; end
    if (!host_ready) begin
      checks++; failures++;
      $display("FAIL idle_timeout: host_ready=%b, required 1", host_ready);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_q();
    act_wq.delete(); exp_wq.delete(); act_rq.delete(); exp_rq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; host_valid = 1'b0; host_mode = 1'b0; host_wdata = 8'h00; host_rd = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (host_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b need 1", host_ready); end
    checks++; if (vram_we !== 1'b0 || vram_re !== 1'b0 || reg_we !== 1'b0 || host_rvalid !== 1'b0) begin
      failures++; $display("FAIL rst_strobes: we=%b re=%b reg_we=%b rvalid=%b need 0", vram_we, vram_re, reg_we, host_rvalid); end
    checks++; if (latch_pending !== 1'b0) begin failures++; $display("FAIL rst_latch: got %b need 0", latch_pending); end
    checks++; if (vram_addr !== 14'h0 || vram_wdata !== 8'h0 || host_rdata !== 8'h0) begin
      failures++; $display("FAIL rst_data: addr=%h wdata=%h rdata=%h need 0", vram_addr, vram_wdata, host_rdata); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_q(); gnt_mode = 0;
    put(1'b1, 8'h34);
    checks++; if (latch_pending !== 1'b1) begin failures++; $display("FAIL basic_latch1: got %b need 1", latch_pending); end
    put(1'b1, 8'h52);
    checks++; if (latch_pending !== 1'b0) begin failures++; $display("FAIL basic_latch0: got %b need 0", latch_pending); end
    put(1'b0, 8'hAA);
    put(1'b0, 8'hBB);
    wait_idle();
    checks++;
    if (act_wq.size() != 2) begin failures++; $display("FAIL basic_count: got %0d writes need 2", act_wq.size()); end
    else begin
      checks++; if (act_wq[0] !== {14'h1234, 8'hAA}) begin failures++; $display("FAIL basic_w0: got %h need %h", act_wq[0], {14'h1234, 8'hAA}); end
      checks++; if (act_wq[1] !== {14'h1235, 8'hBB}) begin failures++; $display("FAIL basic_w1: got %h need %h", act_wq[1], {14'h1235, 8'hBB}); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d [3];
    logic [13:0] a [3];
    clear_q(); gnt_mode = 0;
    a[0] = 14'h3FFF; a[1] = 14'h0000; a[2] = 14'h0001;
    put(1'b1, 8'hFF); put(1'b1, 8'h7F);
    for (int i = 0; i < 3; i++) begin d[i] = 8'($urandom); put(1'b0, d[i]); end
    wait_idle();
    checks++;
    if (act_wq.size() != 3) begin failures++; $display("FAIL wrap_count: got %0d writes need 3", act_wq.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_wq[i] !== {a[i], d[i]}) begin failures++; $display("FAIL wrap_w%0d: got %h need %h", i, act_wq[i], {a[i], d[i]}); end
    end
  endtask

  task automatic test_reg_write();
    clear_q(); gnt_mode = 0;
    put(1'b1, 8'h0F); put(1'b1, 8'h87);
    wait_idle();
    checks++;
    if (act_rq.size() != 1) begin failures++; $display("FAIL reg_pulses: got %0d strobe cycles need 1", act_rq.size()); end
    else begin
      checks++; if (act_rq[0] !== {3'd7, 8'h0F}) begin failures++; $display("FAIL reg_value: got %h need %h", act_rq[0], {3'd7, 8'h0F}); end
    end
    checks++; if (act_wq.size() != 0) begin failures++; $display("FAIL reg_no_vram: got %0d writes need 0", act_wq.size()); end
  endtask

  task automatic test_grant_hold();
    clear_q();
    we_cycles = 0; hold_cnt = 5; gnt_mode = 2;
    put(1'b0, 8'h3C);
    wait_idle();
    gnt_mode = 0;
    checks++; if (we_cycles != 6) begin failures++; $display("FAIL hold_we_cycles: got %0d need 6", we_cycles); end
    checks++;
    if (act_wq.size() != 1) begin failures++; $display("FAIL hold_count: got %0d writes need 1", act_wq.size()); end
    else begin
      checks++; if (act_wq[0] !== exp_wq[0]) begin failures++; $display("FAIL hold_w0: got %h need %h", act_wq[0], exp_wq[0]); end
    end
  endtask

  task automatic test_random();
    logic m;
    logic [7:0] d;
    clear_q(); gnt_mode = 1;
    for (int i = 0; i < 60; i++) begin
      m = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      put(m, d);
      checks++;
      if (latch_pending !== m_pend) begin failures++; $display("FAIL rand_latch%0d: got %b need %b", i, latch_pending, m_pend); end
    end
    wait_idle();
    gnt_mode = 0;
    checks++;
    if (act_wq.size() != exp_wq.size()) begin failures++; $display("FAIL rand_wcount: got %0d need %0d", act_wq.size(), exp_wq.size()); end
    else foreach (exp_wq[i]) begin
      checks++;
      if (act_wq[i] !== exp_wq[i]) begin failures++; $display("FAIL rand_w%0d: got %h need %h", i, act_wq[i], exp_wq[i]); end
    end
    checks++;
    if (act_rq.size() != exp_rq.size()) begin failures++; $display("FAIL rand_rcount: got %0d need %0d", act_rq.size(), exp_rq.size()); end
    else foreach (exp_rq[i]) begin
      checks++;
      if (act_rq[i] !== exp_rq[i]) begin failures++; $display("FAIL rand_r%0d: got %h need %h", i, act_rq[i], exp_rq[i]); end
    end
  endtask

`ifdef VDP_READBACK_EN
  task automatic do_read(output logic [7:0] d, output logic ok);
    int n = 0;
    @(negedge clk);
    host_rd = 1'b1;
    while (!host_rvalid && n < 200) begin @(negedge clk); n++; end
    ok = host_rvalid; d = host_rdata;
    host_rd = 1'b0;
  endtask

  task automatic test_readback();
    logic [7:0] got, want;
    logic ok;
    logic [7:0] pv [2];
    gnt_mode = 1;
    pv[0] = 8'h11; pv[1] = 8'h22;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      poke_en = 1'b1; poke_addr = 14'h0100 + 14'(i); poke_data = pv[i];
      ref_mem[14'h0100 + 14'(i)] = pv[i];
    end
    @(negedge clk); poke_en = 1'b0;
    put(1'b1, 8'h00); put(1'b1, 8'h01);
    for (int i = 0; i < 2; i++) begin
      do_read(got, ok);
      want = m_buf;
      m_buf = ref_mem[m_addr]; m_addr = m_addr + 14'd1;
      checks++;
      if (ok !== 1'b1 || got !== want) begin failures++; $display("FAIL read%0d: rvalid=%b data=%h need 1/%h", i, ok, got, want); end
    end
    wait_idle();
    gnt_mode = 0;
  endtask
`endif

  task automatic test_reset_mid();
    clear_q();
    hold_cnt = 20; gnt_mode = 2;
    send_byte(1'b1, 8'h34); send_byte(1'b1, 8'h52);
    send_byte(1'b0, 8'hAA);
    repeat (2) @(negedge clk);
    checks++; if (vram_we !== 1'b1) begin failures++; $display("FAIL mid_pending: vram_we=%b need 1", vram_we); end
    reset_n = 1'b0;
    #1;
    checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL mid_we_drop: vram_we=%b need 0", vram_we); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1; gnt_mode = 0; hold_cnt = 0;
    m_addr = '0; m_lo = '0; m_pend = 1'b0;
    @(negedge clk);
    checks++; if (host_ready !== 1'b1 || latch_pending !== 1'b0) begin
      failures++; $display("FAIL mid_release: ready=%b latch=%b need 1/0", host_ready, latch_pending); end
    checks++; if (act_wq.size() != 0) begin failures++; $display("FAIL mid_no_write: got %0d writes need 0", act_wq.size()); end
    put(1'b0, 8'h5A);
    wait_idle();
    checks++;
    if (act_wq.size() != 1 || act_wq[0] !== {14'h0000, 8'h5A}) begin
      failures++; $display("FAIL mid_addr0: got %0d writes first=%h need 1 at %h", act_wq.size(),
                           (act_wq.size() > 0) ? act_wq[0] : 22'h0, {14'h0000, 8'h5A}); end
  endtask

  task automatic test_invariants();
    checks++; if (both_hi != 0) begin failures++; $display("FAIL we_re_overlap: got %0d cycles need 0", both_hi); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL we_stability: got %0d changes need 0", unstable); end
    checks++; if (busy_ready != 0) begin failures++; $display("FAIL busy_ready: got %0d cycles need 0", busy_ready); end
  endtask

  initial begin
    vram_gnt = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_reg_write();
    test_grant_hold();
    test_random();
`ifdef VDP_READBACK_EN
    test_readback();
`endif
    test_reset_mid();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
